dmem_arbiter: RTL and testbench

- Shares the single-port 1024x32 data memory between two requesters: port 0 is the CPU load/store unit, port 1 is the loader/debug DMA.
- Round-robin arbitration with single-beat req/ready transactions.
- Optional bounded lock gives a requester back-to-back beats.
- Sits between the requesters and the data memory; that memory has asynchronous read and a synchronous write, gated by its write enable.

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_rr_pick.sv | 19 +
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and width constants for the data memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int LOCK_CNT_W = 8;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-input round-robin picker honouring an active lock
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_gnt,
    input  arb_state_t lock_state,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    always_comb begin
        gnt_valid = (lock_state == LOCK0) ? valid0 :
                    (lock_state == LOCK1) ? valid1 : (valid0 | valid1);
        gnt_idx   = (lock_state == LOCK0) ? 1'b0 :
                    (lock_state == LOCK1) ? 1'b1 :
                    (valid0 & valid1) ? ~last_gnt : valid1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the data memory between LSU and DMA, with bounded lock
// Optional DMEM_ARB_STATS_EN adds per-port beat counters and a lock eviction pulse.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic              lock_evict
`endif
);
    localparam logic [LOCK_CNT_W:0] LOCK_LIM = (LOCK_CNT_W+1)'(LOCK_MAX);
    arb_state_t            state;
    logic                  last_gnt;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  pick_valid;
    logic                  pick_idx;
    logic                  gnt;
    logic                  g_lock;
    logic [LOCK_CNT_W:0]   cnt_nxt;
    logic                  cnt_hit;
    dmem_rr_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_gnt   (last_gnt),
        .lock_state (state),
        .gnt_valid  (pick_valid),
        .gnt_idx    (pick_idx)
    );
    always_comb begin
        gnt        = pick_valid & ~rst;
        busy       = gnt;
        owner      = gnt & pick_idx;
        req0_ready = gnt & ~pick_idx;
        req1_ready = gnt & pick_idx;
        mem_addr   = !gnt ? '0 : pick_idx ? req1_addr : req0_addr;
        mem_wdata  = !gnt ? '0 : pick_idx ? req1_wdata : req0_wdata;
        mem_we     = gnt & (pick_idx ? req1_we : req0_we);
        req0_rdata = req0_ready ? mem_rdata : '0;
        req1_rdata = req1_ready ? mem_rdata : '0;
        g_lock     = pick_idx ? req1_lock : req0_lock;
        cnt_nxt    = {1'b0, lock_cnt} + (LOCK_CNT_W+1)'(1);
        cnt_hit    = cnt_nxt >= LOCK_LIM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OPEN;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
        end else if (gnt) begin
            last_gnt <= pick_idx;
            state    <= (g_lock && !cnt_hit) ? (pick_idx ? LOCK1 : LOCK0) : OPEN;
            lock_cnt <= (g_lock && !cnt_hit) ? cnt_nxt[LOCK_CNT_W-1:0] : '0;
        end else if (state != OPEN) begin
            state    <= OPEN;
            lock_cnt <= '0;
        end
    end
`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
            lock_evict <= 1'b0;
        end else begin
            gnt_cnt0   <= gnt_cnt0 + 16'(req0_ready && gnt_cnt0 != 16'hFFFF);
            gnt_cnt1   <= gnt_cnt1 + 16'(req1_ready && gnt_cnt1 != 16'hFFFF);
            lock_evict <= gnt & g_lock & cnt_hit;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, hand sequences and randomized traffic against a port-level model
module tb_dmem_arbiter;
    localparam int LM = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_we, req0_lock, req0_ready;
    logic [9:0]  req0_addr;
    logic [31:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_we, req1_lock, req1_ready;
    logic [9:0]  req1_addr;
    logic [31:0] req1_wdata, req1_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, owner, busy;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
    logic        lock_evict;
`endif
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int pass_cnt = 0;
    int total_cnt = 0;
    int m_lock, m_beats, m_pref, m_cnt0, m_cnt1, m_evict;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
        .req1_rdata(req1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .lock_evict(lock_evict)
`endif
    );

    typedef struct {
        logic        rst, v0, we0, lk0, v1, we1, lk1;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        chk_en, eb, eo, ew;
        logic [31:0] er0, er1;
    } vec_t;

    function automatic vec_t mk(input logic r, v0, we0, lk0, input logic [9:0] a0,
                                input logic [31:0] d0, input logic v1, we1, lk1,
                                input logic [9:0] a1, input logic [31:0] d1,
                                input logic eb, eo, ew, input logic [31:0] er0, er1);
        vec_t t;
        t.rst = r; t.v0 = v0; t.we0 = we0; t.lk0 = lk0; t.a0 = a0; t.d0 = d0;
        t.v1 = v1; t.we1 = we1; t.lk1 = lk1; t.a1 = a1; t.d1 = d1;
        t.chk_en = 1'b1; t.eb = eb; t.eo = eo; t.ew = ew; t.er0 = er0; t.er1 = er1;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    endtask

    task automatic model_reset();
        m_lock = -1; m_beats = 0; m_pref = 0; m_cnt0 = 0; m_cnt1 = 0; m_evict = 0;
    endtask

    task automatic cycle(input vec_t t);
        logic v[2], we[2], lk[2];
        logic [9:0] a[2];
        logic [31:0] d[2];
        int g;
        logic cw;
        logic [9:0] ca;
        logic [31:0] cd;
        @(negedge clk);
        rst = t.rst;
        req0_valid = t.v0; req0_we = t.we0; req0_lock = t.lk0; req0_addr = t.a0; req0_wdata = t.d0;
        req1_valid = t.v1; req1_we = t.we1; req1_lock = t.lk1; req1_addr = t.a1; req1_wdata = t.d1;
        v[0] = t.v0; we[0] = t.we0; lk[0] = t.lk0; a[0] = t.a0; d[0] = t.d0;
        v[1] = t.v1; we[1] = t.we1; lk[1] = t.lk1; a[1] = t.a1; d[1] = t.d1;
        #1;
        g = -1;
        if (!t.rst) begin
            if (m_lock >= 0) g = v[m_lock] ? m_lock : -1;
            else if (v[0] && v[1]) g = m_pref;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
        end
        chk("busy", 32'(busy), 32'(g >= 0));
        chk("owner", 32'(owner), 32'(g == 1));
        chk("ready0", 32'(req0_ready), 32'(g == 0));
        chk("ready1", 32'(req1_ready), 32'(g == 1));
        chk("mem_we", 32'(mem_we), 32'(g >= 0 && we[g >= 0 ? g : 0]));
        chk("mem_addr", 32'(mem_addr), g >= 0 ? 32'(a[g]) : 32'd0);
        chk("mem_wdata", mem_wdata, g >= 0 ? d[g] : 32'd0);
        chk("rdata0", req0_rdata, g == 0 ? ref_mem[a[0]] : 32'd0);
        chk("rdata1", req1_rdata, g == 1 ? ref_mem[a[1]] : 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
        chk("lock_evict", 32'(lock_evict), 32'(m_evict));
`endif
        if (t.chk_en) begin
            chk("tbl_busy", 32'(busy), 32'(t.eb));
            chk("tbl_owner", 32'(owner), 32'(t.eo));
            chk("tbl_we", 32'(mem_we), 32'(t.ew));
            chk("tbl_rdata0", req0_rdata, t.er0);
            chk("tbl_rdata1", req1_rdata, t.er1);
        end
        cw = mem_we; ca = mem_addr; cd = mem_wdata;
        @(posedge clk);
        if (cw) mem[ca] = cd;
        m_evict = 0;
        if (t.rst) model_reset();
        else if (g >= 0) begin
            m_pref = 1 - g;
            if (we[g]) ref_mem[a[g]] = d[g];
            if (g == 0) m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
            else m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
            if (lk[g] && m_beats + 1 < LM) begin
                m_lock = g; m_beats++;
            end else begin
                m_evict = lk[g] ? 1 : 0;
                m_lock = -1; m_beats = 0;
            end
        end else if (m_lock >= 0) begin
            m_lock = -1; m_beats = 0;
        end
    endtask

    vec_t tbl[$];
    vec_t t;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        model_reset();
        // rst, v0, we0, lk0, a0, d0, v1, we1, lk1, a1, d1, busy, owner, we, r0, r1
        tbl.push_back(mk(1, 1,1,0, 10'd5, 32'h1, 1,1,0, 10'd5, 32'h2, 0,0,0, 0, 0));
        tbl.push_back(mk(0, 1,1,0, 10'd5, DB,    0,0,0, 10'd0, 32'h0, 1,0,1, 0, 0));
        tbl.push_back(mk(0, 0,0,0, 10'd0, 32'h0, 1,0,0, 10'd5, 32'h0, 1,1,0, 0, DB));
        tbl.push_back(mk(1, 0,0,0, 10'd0, 32'h0, 0,0,0, 10'd0, 32'h0, 0,0,0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1,0,0, 10'd5, 32'h0, 1,0,0, 10'd5, 32'h0, 1, i[0], 0,
                             i[0] ? 32'd0 : DB, i[0] ? DB : 32'd0));
        tbl.push_back(mk(1, 0,0,0, 10'd0, 32'h0, 0,0,0, 10'd0, 32'h0, 0,0,0, 0, 0));
        for (int i = 0; i < LM; i++)
            tbl.push_back(mk(0, 1,0,1, 10'd5, 32'h0, 1,0,0, 10'd5, 32'h0, 1,0,0, DB, 0));
        tbl.push_back(mk(0, 1,0,1, 10'd5, 32'h0, 1,0,0, 10'd5, 32'h0, 1,1,0, 0, DB));
        tbl.push_back(mk(0, 0,0,0, 10'd5, 32'h0, 1,0,1, 10'd5, 32'h0, 1,1,0, 0, DB));
        tbl.push_back(mk(0, 1,0,0, 10'd5, 32'h0, 0,0,0, 10'd5, 32'h0, 0,0,0, 0, 0));
        tbl.push_back(mk(0, 1,0,0, 10'd5, 32'h0, 0,0,0, 10'd5, 32'h0, 1,0,0, DB, 0));
        foreach (tbl[i]) begin
            cycle(tbl[i]);
`ifdef DMEM_ARB_STATS_EN
            if (i == 8 + LM) chk("evict_after_lock", 32'(lock_evict), 32'd1);
`endif
        end

        // reset while LOCK0 holds a pending write
        cycle(mk(1, 0,0,0, 10'd0, 32'h0, 0,0,0, 10'd0, 32'h0, 0,0,0, 0, 0));
        cycle(mk(0, 1,1,1, 10'd7, 32'h11111111, 0,0,0, 10'd0, 32'h0, 1,0,1, 0, 0));
        cycle(mk(1, 1,1,1, 10'd7, 32'h22222222, 1,0,0, 10'd7, 32'h0, 0,0,0, 0, 0));
        cycle(mk(0, 1,0,0, 10'd7, 32'h0, 1,0,0, 10'd7, 32'h0, 1,0,0, 32'h11111111, 0));
        cycle(mk(0, 1,0,0, 10'd7, 32'h0, 1,0,0, 10'd7, 32'h0, 1,1,0, 0, 32'h11111111));
        chk("mem7_after_rst", mem[7], 32'h11111111);

        for (int n = 0; n < 3000; n++) begin
            t = mk($urandom_range(63) == 0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
                   10'($urandom_range(15)), $urandom, $urandom_range(1), $urandom_range(1),
                   $urandom_range(1), 10'($urandom_range(15)), $urandom, 0,0,0, 0, 0);
            t.chk_en = 1'b0;
            cycle(t);
        end

`ifdef DMEM_ARB_STATS_EN
        t = mk(1, 0,0,0, 10'd0, 32'h0, 0,0,0, 10'd0, 32'h0, 0,0,0, 0, 0);
        t.chk_en = 1'b0;
        cycle(t);
        t.rst = 1'b0; t.v1 = 1'b1; t.a1 = 10'd5;
        for (int n = 0; n < 70000; n++) cycle(t);
        t.v1 = 1'b0;
        cycle(t);
        chk("gnt_cnt1_sat", 32'(gnt_cnt1), 32'hFFFF);
        chk("gnt_cnt0_zero", 32'(gnt_cnt0), 32'h0);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
